// File: rtl/mem_port_arbiter.sv
// Arbitrates one synchronous-read RAM between fetch and data ports, with data priority,
// a starvation guard for fetch, response routing and a fetch-conflict counter.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_wmask,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_wmask,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic [1:0] {StNone, StIResp, StDResp} owner_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    owner_e      owner_q, owner_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] i_hold_q, i_hold_d;
    logic [31:0] d_hold_q, d_hold_d;
    logic [15:0] conflict_q, conflict_d;
    logic        d_win, i_win;

    // Grants are gated by reset so nothing reaches the RAM while resetn is low.
    assign d_win = resetn & d_req & ~(i_req & (starve_q == StarveMax));
    assign i_win = resetn & i_req & ~d_win;

    assign d_gnt = d_win;
    assign i_gnt = i_win;

    always_comb begin
        ram_en    = i_win | d_win;
        ram_addr  = '0;
        ram_wmask = '0;
        if (d_win) begin
            ram_addr  = d_addr;
            ram_wmask = d_wmask;
        end else if (i_win) begin
            ram_addr = i_addr;
        end
    end

    assign ram_wdata = resetn ? d_wdata : '0;

    always_comb begin
        starve_d = starve_q;
        if (!i_req || i_win) begin
            starve_d = '0;
        end else if (d_win && (starve_q != StarveMax)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Owner of the read data returning next cycle; writes and flushed fetches get none.
    always_comb begin
        owner_d = StNone;
        if (i_win && !i_flush) begin
            owner_d = StIResp;
        end else if (d_win && (d_wmask == 4'b0000)) begin
            owner_d = StDResp;
        end
    end

    assign i_rvalid = (owner_q == StIResp) & ~i_flush;
    assign d_rvalid = (owner_q == StDResp);

    always_comb begin
        i_hold_d = i_rvalid ? ram_rdata : i_hold_q;
        d_hold_d = d_rvalid ? ram_rdata : d_hold_q;
    end

    assign i_rdata = i_hold_d;
    assign d_rdata = d_hold_d;

    always_comb begin
        conflict_d = conflict_q;
        if (i_req && !i_win && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q    <= StNone;
            starve_q   <= '0;
            i_hold_q   <= '0;
            d_hold_q   <= '0;
            conflict_q <= '0;
        end else begin
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            i_hold_q   <= i_hold_d;
            d_hold_q   <= d_hold_d;
            conflict_q <= conflict_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus random traffic, with a
// RAM model on the RAM port and an independent word-level reference of memory and grants.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 14;
    localparam int STARVE_MAX = 4;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] data;
    } resp_t;

    logic              clk = 1'b0;
    logic              resetn;
    logic              i_req, i_flush, i_gnt, i_rvalid;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_rdata;
    logic              d_req, d_gnt, d_rvalid;
    logic [ADDR_W-1:0] d_addr;
    logic [3:0]        d_wmask;
    logic [31:0]       d_wdata, d_rdata;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_wmask;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = '0;
    logic [15:0]       conflict_cnt;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_wmask(ram_wmask), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model with a side-load port used only on idle cycles.
    logic [31:0] mem [64];
    logic        ld_en = 1'b0;
    logic [5:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_wmask[b]) mem[ram_addr[5:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            if (ram_wmask == 4'b0000) ram_rdata <= mem[ram_addr[5:0]];
        end
    end

    int          errors = 0;
    int          checks = 0;
    logic [31:0] ref_mem [64];
    resp_t       iq[$];
    resp_t       dq[$];
    logic        pend_i = 1'b0;
    logic [31:0] pend_data = '0;
    int          m_wait = 0;
    int          m_conf = 0;
    logic [31:0] exp_ihold = '0;
    logic [31:0] exp_dhold = '0;
    string       act_log = "";

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One bus cycle: drive at the falling edge, check grants/RAM drive, advance the model.
    task automatic cycle(input logic ir, input logic [ADDR_W-1:0] ia, input logic fl,
                         input logic dr, input logic [ADDR_W-1:0] da, input logic [3:0] wm,
                         input logic [31:0] wd);
        logic eg_d, eg_i;
        logic [ADDR_W-1:0] ea;
        resp_t r;
        i_req = ir; i_addr = ia; i_flush = fl;
        d_req = dr; d_addr = da; d_wmask = wm; d_wdata = wd;
        if (pend_i && !fl) begin
            r.cyc = cyc; r.data = pend_data;
            iq.push_back(r);
        end
        pend_i = 1'b0;
        eg_d = dr && !(ir && m_wait == STARVE_MAX);
        eg_i = ir && !eg_d;
        ea = eg_d ? da : (eg_i ? ia : '0);
        #1;
        chk("d_gnt", d_gnt, eg_d);
        chk("i_gnt", i_gnt, eg_i);
        chk("ram_en", ram_en, eg_d | eg_i);
        chk("ram_addr", ram_addr, ea);
        chk("ram_wmask", ram_wmask, eg_d ? wm : 4'b0000);
        chk("ram_wdata", ram_wdata, wd);
        chk("conflict_cnt", conflict_cnt, m_conf);
        act_log = {act_log, d_gnt ? "D" : (i_gnt ? "I" : "-")};
        if (ir && !eg_i && m_conf < 65535) m_conf++;
        if (!ir || eg_i) m_wait = 0;
        else if (m_wait < STARVE_MAX) m_wait++;
        if (eg_i && !fl) begin
            pend_i = 1'b1;
            pend_data = ref_mem[ia[5:0]];
        end
        if (eg_d) begin
            if (wm == 4'b0000) begin
                r.cyc = cyc + 1; r.data = ref_mem[da[5:0]];
                dq.push_back(r);
            end else begin
                for (int b = 0; b < 4; b++)
                    if (wm[b]) ref_mem[da[5:0]][8*b +: 8] = wd[8*b +: 8];
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 4'b0000, 32'h0);
    endtask

    task automatic load_word(input int a, input logic [31:0] d);
        ref_mem[a] = d;
        ld_en = 1'b1; ld_addr = 6'(a); ld_data = d;
        idle();
        ld_en = 1'b0;
    endtask

    // Asserts reset at a falling edge with both ports requesting, then releases it.
    task automatic do_reset();
        resetn = 1'b0;
        i_req = 1'b1; d_req = 1'b1; i_flush = 1'b0; d_wmask = 4'hF; d_wdata = 32'hDEADBEEF;
        i_addr = 14'd7; d_addr = 14'd9;
        iq.delete(); dq.delete();
        pend_i = 1'b0; m_wait = 0; m_conf = 0; exp_ihold = '0; exp_dhold = '0;
        #1;
        chk("rst_i_gnt", i_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_i_rvalid", i_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wmask", ram_wmask, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_conflict", conflict_cnt, 0);
        repeat (2) @(negedge clk);
        i_req = 1'b0; d_req = 1'b0; d_wmask = 4'b0000;
        resetn = 1'b1;
    endtask

    // Monitor: pops expected responses whenever the DUT presents read data.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (i_rvalid) begin
                if (iq.size() == 0) begin
                    chk("i_rvalid_unexpected", 32'(i_rvalid), 0);
                end else begin
                    e = iq.pop_front();
                    chk("i_resp_cycle", cyc, e.cyc);
                    chk("i_rdata", i_rdata, e.data);
                    exp_ihold = e.data;
                end
            end else begin
                if (iq.size() > 0 && iq[0].cyc <= 32'(cyc)) begin
                    e = iq.pop_front();
                    chk("i_rvalid_missing", 32'(i_rvalid), 1);
                end
                chk("i_rdata_hold", i_rdata, exp_ihold);
            end
            if (d_rvalid) begin
                if (dq.size() == 0) begin
                    chk("d_rvalid_unexpected", 32'(d_rvalid), 0);
                end else begin
                    e = dq.pop_front();
                    chk("d_resp_cycle", cyc, e.cyc);
                    chk("d_rdata", d_rdata, e.data);
                    exp_dhold = e.data;
                end
            end else begin
                if (dq.size() > 0 && dq[0].cyc <= 32'(cyc)) begin
                    e = dq.pop_front();
                    chk("d_rvalid_missing", 32'(d_rvalid), 1);
                end
                chk("d_rdata_hold", d_rdata, exp_dhold);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
        d_req = 1'b0; d_addr = '0; d_wmask = '0; d_wdata = '0;
        @(negedge clk);
        do_reset();
        for (int a = 0; a < 64; a++) load_word(a, $urandom);

        // Continuous contention straight out of reset.
        do_reset();
        act_log = "";
        for (int k = 0; k < 10; k++) cycle(1'b1, 14'd0, 1'b0, 1'b1, 14'd1, 4'b0000, 32'h0);
        checks++;
        if (act_log != "DDDDIDDDDI") begin
            errors++;
            $display("FAIL grant_pattern: got %s expected DDDDIDDDDI", act_log);
        end
        chk("conflict_after_contention", conflict_cnt, 32'd8);
        idle();

        // Fetch only.
        load_word(0, 32'h11); load_word(1, 32'h22); load_word(2, 32'h33);
        for (int a = 0; a < 3; a++) cycle(1'b1, 14'(a), 1'b0, 1'b0, '0, 4'b0000, 32'h0);
        idle(); idle();
        chk("i_rdata_last", i_rdata, 32'h33);

        // Flush in grant cycle, then flush in response cycle.
        cycle(1'b1, 14'd1, 1'b1, 1'b0, '0, 4'b0000, 32'h0);
        idle(); idle();
        cycle(1'b1, 14'd1, 1'b0, 1'b0, '0, 4'b0000, 32'h0);
        cycle(1'b0, 14'd0, 1'b1, 1'b0, '0, 4'b0000, 32'h0);
        idle();
        chk("i_rdata_after_flush", i_rdata, 32'h33);

        // Store then load with byte merge.
        load_word(5, 32'h12345678);
        cycle(1'b0, '0, 1'b0, 1'b1, 14'd5, 4'b0100, 32'h00AB0000);
        cycle(1'b0, '0, 1'b0, 1'b1, 14'd5, 4'b0000, 32'h0);
        idle();
        chk("d_rdata_merge", d_rdata, 32'h12AB5678);

        // Reset the cycle after a data read grant.
        cycle(1'b1, 14'd0, 1'b0, 1'b1, 14'd3, 4'b0000, 32'h0);
        do_reset();
        idle(); idle();

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            logic [3:0] wm;
            wm = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            cycle(1'($urandom_range(0, 3) != 0), 14'($urandom_range(0, 63)),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0),
                  14'($urandom_range(0, 63)), wm, $urandom);
        end
        idle(); idle(); idle();
        chk("iq_drained", iq.size(), 0);
        chk("dq_drained", dq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
